// File: rtl/xintf_dpbram_bridge.sv
// xintf_dpbram_bridge: DSP-side XINTF to dual-port BRAM mailbox bridge.
// Asynchronous XINTF strobes are synchronized, then a small FSM turns each
// DSP access into one BRAM read (Zynq-written RAM) or one BRAM write
// (Zynq-read RAM). Define DSP_LINK_WDT_EN to add a link watchdog that raises
// o_link_lost after WDT_CYCLES clocks with no DSP access.
module xintf_dpbram_bridge #(
    parameter int ADDR_W      = 9,
    parameter int SYNC_STAGES = 2,
    parameter int RAM_RD_LAT  = 2,
    parameter int WR_ADDR_MAX = 10,
    parameter int WDT_CYCLES  = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_xintf_zcs_n,
    input  logic              i_xintf_rd_n,
    input  logic              i_xintf_we_n,
    input  logic [ADDR_W-1:0] i_xintf_addr,
    input  logic [15:0]       i_xintf_data,
    output logic [15:0]       o_xintf_data,
    output logic              o_xintf_data_oe,
    output logic [ADDR_W-1:0] o_dsp_r_ram_addr,
    output logic              o_dsp_r_ram_ce,
    input  logic [15:0]       i_dsp_r_ram_dout,
    output logic [ADDR_W-1:0] o_dsp_w_ram_addr,
    output logic [15:0]       o_dsp_w_ram_din,
    output logic              o_dsp_w_ram_ce,
    output logic              o_wr_err,
    output logic              o_link_lost
);
    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_ACT, WR_COMMIT, WAIT_REL
    } state_t;

    state_t state, nxt;
    logic [SYNC_STAGES-1:0] cs_sr, rd_sr, we_sr;
    logic cs_s, rd_s, we_s;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0] data_q;
    logic [7:0] lat_cnt;
    logic wr_ok, latch_en;

    assign cs_s = cs_sr[SYNC_STAGES-1];
    assign rd_s = rd_sr[SYNC_STAGES-1];
    assign we_s = we_sr[SYNC_STAGES-1];
    assign wr_ok = addr_q <= ADDR_W'(WR_ADDR_MAX);
    // Address/data track the bus in IDLE and while a write strobe stays active.
    assign latch_en = (state == IDLE) || (state == WR_ACT && nxt == WR_ACT);

    // Synchronize the asynchronous XINTF strobes (inactive = 1 after reset).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_sr <= '1;
            rd_sr <= '1;
            we_sr <= '1;
        end else begin
            cs_sr <= (cs_sr << 1) | SYNC_STAGES'(i_xintf_zcs_n);
            rd_sr <= (rd_sr << 1) | SYNC_STAGES'(i_xintf_rd_n);
            we_sr <= (we_sr << 1) | SYNC_STAGES'(i_xintf_we_n);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt;
    end

    // FSM next-state logic; a release during the read pipeline aborts it.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:
                if (!cs_s && !rd_s && !we_s) nxt = WAIT_REL;
                else if (!cs_s && !rd_s)     nxt = RD_ISSUE;
                else if (!cs_s && !we_s)     nxt = WR_ACT;
            RD_ISSUE:  nxt = (cs_s || rd_s) ? IDLE : RD_WAIT;
            RD_WAIT:   nxt = (cs_s || rd_s) ? IDLE :
                             (lat_cnt == 8'(RAM_RD_LAT - 1)) ? RD_HOLD : RD_WAIT;
            RD_HOLD:   nxt = (cs_s || rd_s) ? IDLE : RD_HOLD;
            WR_ACT:    nxt = (cs_s || we_s) ? WR_COMMIT : WR_ACT;
            WR_COMMIT: nxt = IDLE;
            WAIT_REL:  nxt = (cs_s && rd_s && we_s) ? IDLE : WAIT_REL;
            default:   nxt = IDLE;
        endcase
    end

    // FSM outputs: one-clock RAM enables and the write-range error pulse.
    always_comb begin
        o_dsp_r_ram_ce = state == RD_ISSUE;
        o_dsp_w_ram_ce = state == WR_COMMIT && wr_ok;
        o_wr_err       = state == WR_COMMIT && !wr_ok;
    end

    // Bus address/data capture, frozen once a write strobe is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (latch_en) begin
            addr_q <= i_xintf_addr;
            data_q <= i_xintf_data;
        end
    end

    // Read-RAM address is loaded as the read is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                o_dsp_r_ram_addr <= '0;
        else if (state == IDLE && nxt == RD_ISSUE) o_dsp_r_ram_addr <= addr_q;
    end

    // Count BRAM read latency while in RD_WAIT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lat_cnt <= '0;
        else       lat_cnt <= (state == RD_WAIT) ? lat_cnt + 8'd1 : 8'd0;
    end

    // Drive read data to the pad and hold it until the DSP releases the read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_xintf_data    <= '0;
            o_xintf_data_oe <= 1'b0;
        end else if (state == RD_WAIT && nxt == RD_HOLD) begin
            o_xintf_data    <= i_dsp_r_ram_dout;
            o_xintf_data_oe <= 1'b1;
        end else if (state == RD_HOLD && nxt == IDLE) begin
            o_xintf_data_oe <= 1'b0;
        end
    end

    // Write-RAM address/data are set up for the commit cycle and then held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dsp_w_ram_addr <= '0;
            o_dsp_w_ram_din  <= '0;
        end else if (state == WR_ACT && nxt == WR_COMMIT && wr_ok) begin
            o_dsp_w_ram_addr <= addr_q;
            o_dsp_w_ram_din  <= data_q;
        end
    end

`ifdef DSP_LINK_WDT_EN
    logic [31:0] wdt_cnt;

    // Watchdog: cleared by each issued read or write commit, saturates at timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                        wdt_cnt <= '0;
        else if (state == WR_COMMIT || state == RD_ISSUE) wdt_cnt <= '0;
        else if (wdt_cnt != 32'(WDT_CYCLES))              wdt_cnt <= wdt_cnt + 32'd1;
    end

    assign o_link_lost = wdt_cnt == 32'(WDT_CYCLES);
`else
    assign o_link_lost = WDT_CYCLES[0] & 1'b0;
`endif
endmodule

// File: tb/tb_xintf_dpbram_bridge.sv
// tb_xintf_dpbram_bridge: directed self-checking bench for the XINTF/DPBRAM bridge.
module tb_xintf_dpbram_bridge;
    localparam int AW = 9;
`ifdef DSP_LINK_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic          i_clk = 1'b0, i_rst = 1'b1;
    logic          zcs_n = 1'b1, rd_n = 1'b1, we_n = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [15:0]   wdata = '0;
    logic [15:0]   xdata, r_dout, w_din;
    logic          oe, r_ce, w_ce, wr_err, link_lost;
    logic [AW-1:0] r_addr, w_addr;

    logic [15:0] mem [0:511];
    logic [15:0] q1;
    int n_tests = 0, n_fail = 0;
    int r_ce_n = 0, w_ce_n = 0, err_n = 0;
    logic [AW-1:0] r_addr_last = '0;

    xintf_dpbram_bridge #(.WDT_CYCLES(100)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_xintf_zcs_n(zcs_n), .i_xintf_rd_n(rd_n), .i_xintf_we_n(we_n),
        .i_xintf_addr(addr), .i_xintf_data(wdata),
        .o_xintf_data(xdata), .o_xintf_data_oe(oe),
        .o_dsp_r_ram_addr(r_addr), .o_dsp_r_ram_ce(r_ce), .i_dsp_r_ram_dout(r_dout),
        .o_dsp_w_ram_addr(w_addr), .o_dsp_w_ram_din(w_din), .o_dsp_w_ram_ce(w_ce),
        .o_wr_err(wr_err), .o_link_lost(link_lost)
    );

    always #5 i_clk = ~i_clk;

    // Two-clock BRAM read model.
    always @(posedge i_clk) begin
        if (r_ce) q1 <= mem[r_addr];
        r_dout <= q1;
    end

    always @(negedge i_clk) begin
        if (r_ce) begin
            r_ce_n++;
            r_addr_last = r_addr;
        end
        if (w_ce) w_ce_n++;
        if (wr_err) err_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_acc(input logic [AW-1:0] a, input int n_low,
                            output int lat, output int rel, output logic [15:0] d);
        addr = a;
        zcs_n = 1'b0;
        @(negedge i_clk);
        rd_n = 1'b0;
        lat = 99;
        d = 16'hxxxx;
        for (int k = 1; k <= n_low; k++) begin
            @(negedge i_clk);
            if (oe && lat == 99) begin
                lat = k;
                d = xdata;
            end
        end
        rd_n = 1'b1;
        zcs_n = 1'b1;
        rel = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (!oe && rel == 99) rel = k;
        end
    endtask

    task automatic write_acc(input logic [AW-1:0] a, input logic [15:0] d, output int ce_k);
        addr = a;
        wdata = d;
        zcs_n = 1'b0;
        @(negedge i_clk);
        we_n = 1'b0;
        repeat (6) @(negedge i_clk);
        we_n = 1'b1;
        zcs_n = 1'b1;
        ce_k = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (w_ce && ce_k == 99) begin
                ce_k = k;
                chk("wr_addr", 32'(w_addr), 32'(a));
                chk("wr_din", 32'(w_din), 32'(d));
            end
        end
    endtask

    initial begin
        int lat, rel, ce_k, r0, w0, e0;
        logic [15:0] d;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3);
        mem[0] = 16'h0F0F;
        mem[2] = 16'hBEEF;
        mem[4] = 16'hA55A;
        repeat (3) @(negedge i_clk);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_data", 32'(xdata), 0);
        chk("rst_rce", 32'(r_ce), 0);
        chk("rst_wce", 32'(w_ce), 0);
        chk("rst_err", 32'(wr_err), 0);
        chk("rst_lost", 32'(link_lost), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        r0 = r_ce_n;
        read_acc(9'd4, 12, lat, rel, d);
        chk("rd4_lat", 32'(lat), 6);
        chk("rd4_data", 32'(d), 32'h A55A);
        chk("rd4_rel", 32'(rel >= 2 && rel <= 3), 1);
        chk("rd4_rce_n", 32'(r_ce_n - r0), 1);
        chk("rd4_raddr", 32'(r_addr_last), 4);

        w0 = w_ce_n; e0 = err_n;
        write_acc(9'd3, 16'h1234, ce_k);
        chk("wr3_ce_k", 32'(ce_k), 3);
        chk("wr3_ce_n", 32'(w_ce_n - w0), 1);
        chk("wr3_err_n", 32'(err_n - e0), 0);
        chk("wr3_hold_addr", 32'(w_addr), 3);
        chk("wr3_hold_ce", 32'(w_ce), 0);

        w0 = w_ce_n; e0 = err_n;
        write_acc(9'd11, 16'hFFFF, ce_k);
        chk("wr11_ce_n", 32'(w_ce_n - w0), 0);
        chk("wr11_err_n", 32'(err_n - e0), 1);
        chk("wr11_hold_din", 32'(w_din), 32'h1234);

        read_acc(9'd0, 3, lat, rel, d);
        chk("abort_oe", 32'(lat), 99);
        chk("abort_data", 32'(xdata), 32'hA55A);
        read_acc(9'd0, 12, lat, rel, d);
        chk("rd0_lat", 32'(lat), 6);
        chk("rd0_data", 32'(d), 32'h0F0F);

        r0 = r_ce_n; w0 = w_ce_n; e0 = err_n;
        addr = 9'd2;
        zcs_n = 1'b0;
        @(negedge i_clk);
        rd_n = 1'b0;
        we_n = 1'b0;
        repeat (6) @(negedge i_clk);
        rd_n = 1'b1;
        we_n = 1'b1;
        zcs_n = 1'b1;
        repeat (5) @(negedge i_clk);
        chk("both_rce_n", 32'(r_ce_n - r0), 0);
        chk("both_wce_n", 32'(w_ce_n - w0), 0);
        chk("both_err_n", 32'(err_n - e0), 0);
        chk("both_oe", 32'(oe), 0);
        read_acc(9'd2, 12, lat, rel, d);
        chk("rd2_lat", 32'(lat), 6);
        chk("rd2_data", 32'(d), 32'hBEEF);

        repeat (40) @(negedge i_clk);
        chk("wdt_early", 32'(link_lost), 0);
        repeat (80) @(negedge i_clk);
        chk("wdt_lost", 32'(link_lost), 32'(WDT_ON));
        read_acc(9'd4, 12, lat, rel, d);
        chk("wdt_clear", 32'(link_lost), 0);

        addr = 9'd4;
        zcs_n = 1'b0;
        @(negedge i_clk);
        rd_n = 1'b0;
        lat = 99;
        for (int k = 1; k <= 12 && lat == 99; k++) begin
            @(negedge i_clk);
            if (oe) lat = k;
        end
        chk("hold_oe", 32'(lat), 6);
        i_rst = 1'b1;
        #1;
        chk("rst_async_oe", 32'(oe), 0);
        chk("rst_async_data", 32'(xdata), 0);
        rd_n = 1'b1;
        zcs_n = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
